uart_block_packer: RTL and testbench

//  Gathers bytes from the UART receive AXI-Stream into 96-bit blocks for the 3-Way cipher pipeline.

---
 rtl/uart_block_packer_if.sv | 22 ++
 rtl/uart_block_packer.sv | 118 +++++++++++
 tb/tb_uart_block_packer.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_block_packer_if.sv
// Stream bundle between the UART byte source, the block packer and the cipher input.
// The slave modport is the packer's view; the master modport is the environment's view.
interface uart_block_packer_if #(parameter int BLOCK_W = 96);
    logic [7:0]         s_axis_tdata;
    logic               s_axis_tvalid;
    logic               s_axis_tready;
    logic [BLOCK_W-1:0] m_axis_tdata;
    logic               m_axis_tvalid;
    logic               m_axis_tready;
    logic               m_axis_tuser;
    logic [3:0]         fill_level;

    modport slave (
        input  s_axis_tdata, s_axis_tvalid, m_axis_tready,
        output s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, fill_level
    );

    modport master (
        output s_axis_tdata, s_axis_tvalid, m_axis_tready,
        input  s_axis_tready, m_axis_tdata, m_axis_tvalid, m_axis_tuser, fill_level
    );
endinterface

// File: rtl/uart_block_packer.sv
// Packs UART bytes into BLOCK_W-bit blocks (first byte in the MSBs) for the cipher pipeline.
// Define UART_BLOCK_PACKER_TIMEOUT_EN to flush a padded partial block after TIMEOUT idle cycles.
module uart_block_packer #(
    parameter int         BLOCK_W  = 96,
    parameter int         TIMEOUT  = 1000000,
    parameter logic [7:0] PAD_BYTE = 8'h00
) (
    input logic                clk,
    input logic                rst_n,
    uart_block_packer_if.slave bus
);
    localparam int NBYTES = BLOCK_W / 8;

    typedef enum logic {FILL, HOLD} state_e;

    state_e             state_q, state_d;
    logic [BLOCK_W-1:0] data_q, data_d;
    logic [3:0]         fill_q, fill_d;
    logic               tvalid_q, tvalid_d;
    logic               tready_q, tready_d;
    logic               tuser_q, tuser_d;
    logic               s_hs, m_hs, expire;

    // tready_q is only ever high in FILL, so it doubles as the state qualifier.
    assign s_hs = bus.s_axis_tvalid && tready_q;
    assign m_hs = tvalid_q && bus.m_axis_tready;

`ifdef UART_BLOCK_PACKER_TIMEOUT_EN
    localparam int CNT_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    logic [CNT_W-1:0] cnt_q, cnt_d;

    // A handshake on the expiry cycle wins: the counter simply clears.
    always_comb begin
        cnt_d  = '0;
        expire = 1'b0;
        if (state_q == FILL && fill_q != 4'd0 && !s_hs) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) expire = 1'b1;
            else                              cnt_d  = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end
`else
    assign expire = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        fill_d   = fill_q;
        tvalid_d = tvalid_q;
        tready_d = tready_q;
        tuser_d  = tuser_q;
        case (state_q)
            FILL: begin
                tready_d = 1'b1;
                if (s_hs) begin
                    for (int i = 0; i < NBYTES; i++)
                        if (fill_q == 4'(i)) data_d[BLOCK_W-1-8*i -: 8] = bus.s_axis_tdata;
                    if (fill_q == 4'(NBYTES - 1)) begin
                        state_d  = HOLD;
                        tvalid_d = 1'b1;
                        tuser_d  = 1'b0;
                        tready_d = 1'b0;
                        fill_d   = 4'd0;
                    end else begin
                        fill_d = fill_q + 4'd1;
                    end
                end else if (expire) begin
                    for (int i = 0; i < NBYTES; i++)
                        if (4'(i) >= fill_q) data_d[BLOCK_W-1-8*i -: 8] = PAD_BYTE;
                    state_d  = HOLD;
                    tvalid_d = 1'b1;
                    tuser_d  = 1'b1;
                    tready_d = 1'b0;
                    fill_d   = 4'd0;
                end
            end
            HOLD: begin
                tready_d = 1'b0;
                if (m_hs) begin
                    state_d  = FILL;
                    tvalid_d = 1'b0;
                    tready_d = 1'b1;
                end
            end
            default: state_d = FILL;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= FILL;
            data_q   <= '0;
            fill_q   <= 4'd0;
            tvalid_q <= 1'b0;
            tready_q <= 1'b0;
            tuser_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            fill_q   <= fill_d;
            tvalid_q <= tvalid_d;
            tready_q <= tready_d;
            tuser_q  <= tuser_d;
        end
    end

    assign bus.s_axis_tready = tready_q;
    assign bus.m_axis_tdata  = data_q;
    assign bus.m_axis_tvalid = tvalid_q;
    assign bus.m_axis_tuser  = tuser_q;
    assign bus.fill_level    = fill_q;
endmodule

// File: tb/tb_uart_block_packer.sv
// Directed and random checks of uart_block_packer against a byte-queue reference model.
// Timeout cases run only when UART_BLOCK_PACKER_TIMEOUT_EN is defined (DUT built with TIMEOUT=16).
module tb_uart_block_packer;
    localparam int BW  = 96;
    localparam int NB  = BW / 8;
    localparam int TMO = 16;

    typedef struct {
        logic [BW-1:0] data;
        logic          user;
    } blk_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_block_packer_if #(.BLOCK_W(BW)) bus ();
    uart_block_packer #(.BLOCK_W(BW), .TIMEOUT(TMO), .PAD_BYTE(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int   checks = 0;
    int   errors = 0;
    logic [7:0] pend[$];
    blk_t       exp_q[$];
    int   idle = 0;
    int   got = 0;
    bit   took;
    bit   rnd_ready = 0;
    logic [BW-1:0] last_blk;
    logic          last_user;

    task automatic check(input string tag, input logic [BW-1:0] obs, input logic [BW-1:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Reference: blocks are consecutive groups of NB accepted bytes, first byte leftmost.
    function automatic logic [BW-1:0] pack(input int pad_to);
        logic [BW-1:0] b = '0;
        for (int i = 0; i < pad_to; i++) b = {b[BW-9:0], (i < pend.size()) ? pend[i] : 8'h00};
        return b;
    endfunction

    task automatic model_reset();
        pend.delete();
        exp_q.delete();
        idle = 0;
    endtask

    // One clock: observe handshakes on the falling edge, then drive just after the rising edge.
    task automatic step();
        blk_t e;
        @(negedge clk);
        took = bus.s_axis_tvalid && bus.s_axis_tready;
        if (bus.m_axis_tvalid && bus.m_axis_tready) begin
            got++;
            last_blk  = bus.m_axis_tdata;
            last_user = bus.m_axis_tuser;
            if (exp_q.size() == 0) begin
                check("unexpected_block", bus.m_axis_tdata, 'x);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", bus.m_axis_tdata, e.data);
                check("sb_user", BW'(bus.m_axis_tuser), BW'(e.user));
            end
        end
        if (took) begin
            pend.push_back(bus.s_axis_tdata);
            idle = 0;
            if (pend.size() == NB) begin
                exp_q.push_back('{pack(NB), 1'b0});
                pend.delete();
            end
        end else if (pend.size() > 0) begin
`ifdef UART_BLOCK_PACKER_TIMEOUT_EN
            idle++;
            if (idle == TMO) begin
                exp_q.push_back('{pack(NB), 1'b1});
                pend.delete();
                idle = 0;
            end
`endif
        end
        @(posedge clk);
        #1;
        if (rnd_ready) bus.m_axis_tready = ($urandom_range(0, 9) >= 3);
    endtask

    task automatic send_byte(input logic [7:0] b);
        int n = 0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = b;
        do begin
            step();
            n++;
        end while (!took && n < 2000);
        if (!took) check("send_timeout", 0, 1);
        bus.s_axis_tvalid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        bus.m_axis_tready = 1'b1;
        while ((exp_q.size() > 0 || bus.m_axis_tvalid) && n < 2000) begin
            step();
            n++;
        end
        check("drain_empty", BW'(exp_q.size()), 0);
    endtask

    initial begin
        int g0, stable_err, tready_err;
        logic [BW-1:0] held;
        bus.s_axis_tvalid = 1'b0;
        bus.s_axis_tdata  = 8'h00;
        bus.m_axis_tready = 1'b0;

        // Reset values
        #3;
        check("rst_tready", BW'(bus.s_axis_tready), 0);
        check("rst_tvalid", BW'(bus.m_axis_tvalid), 0);
        check("rst_tdata",  bus.m_axis_tdata, 0);
        check("rst_tuser",  BW'(bus.m_axis_tuser), 0);
        check("rst_fill",   BW'(bus.fill_level), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        check("tready_before_edge", BW'(bus.s_axis_tready), 0);
        step();
        check("tready_after_edge", BW'(bus.s_axis_tready), 1);

        // Test 1: back-to-back 00..0B
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < NB; i++) begin
            send_byte(8'(i));
            if (i == 4) check("fill_mid", BW'(bus.fill_level), 5);
        end
        check("t1_tvalid", BW'(bus.m_axis_tvalid), 1);
        check("t1_data", bus.m_axis_tdata, 96'h000102030405060708090A0B);
        check("t1_tuser", BW'(bus.m_axis_tuser), 0);
        check("t1_fill_hold", BW'(bus.fill_level), 0);
        check("t1_tready_hold", BW'(bus.s_axis_tready), 0);
        step();
        check("t1_tready_back", BW'(bus.s_axis_tready), 1);
        check("t1_tvalid_drop", BW'(bus.m_axis_tvalid), 0);

        // Test 2: 24 bytes with a 50-clock downstream stall on block 1
        bus.m_axis_tready = 1'b0;
        for (int i = 0; i < NB; i++) send_byte(8'h10 + 8'(i));
        check("t2_blk1", bus.m_axis_tdata, 96'h101112131415161718191A1B);
        held = bus.m_axis_tdata;
        stable_err = 0;
        tready_err = 0;
        bus.s_axis_tvalid = 1'b1;
        bus.s_axis_tdata  = 8'h1C;
        for (int i = 0; i < 50; i++) begin
            step();
            if (bus.m_axis_tdata !== held || bus.m_axis_tvalid !== 1'b1) stable_err++;
            if (bus.s_axis_tready !== 1'b0 || took) tready_err++;
        end
        check("t2_stable", BW'(stable_err), 0);
        check("t2_stall_tready", BW'(tready_err), 0);
        bus.m_axis_tready = 1'b1;
        for (int i = 0; i < NB; i++) send_byte(8'h1C + 8'(i));
        check("t2_blk2", bus.m_axis_tdata, 96'h1C1D1E1F2021222324252627);
        drain();

        // Test 3: random bytes, 30% idle on both sides
        g0 = got;
        rnd_ready = 1;
        for (int i = 0; i < 100 * NB; i++) begin
            while ($urandom_range(0, 9) < 3) step();
            send_byte(8'($urandom));
        end
        rnd_ready = 0;
        drain();
        check("t3_blocks", BW'(got - g0), 100);

        // Test 4: reset mid-block discards the partial block
        for (int i = 0; i < 5; i++) send_byte(8'hA1 + 8'(i));
        rst_n = 1'b0;
        model_reset();
        #1;
        check("t4_fill_rst", BW'(bus.fill_level), 0);
        check("t4_tready_rst", BW'(bus.s_axis_tready), 0);
        step(); step(); step();
        rst_n = 1'b1;
        g0 = got;
        for (int i = 0; i < NB; i++) send_byte(8'hC0 + 8'(i));
        drain();
        check("t4_blocks", BW'(got - g0), 1);
        check("t4_data", last_blk, 96'hC0C1C2C3C4C5C6C7C8C9CACB);

`ifdef UART_BLOCK_PACKER_TIMEOUT_EN
        // Test 5: timeout flush of a 3-byte partial block
        bus.m_axis_tready = 1'b0;
        send_byte(8'hDE); send_byte(8'hAD); send_byte(8'hBE);
        for (int i = 0; i < TMO - 1; i++) step();
        check("t5_no_early", BW'(bus.m_axis_tvalid), 0);
        step();
        check("t5_tvalid", BW'(bus.m_axis_tvalid), 1);
        check("t5_data", bus.m_axis_tdata, 96'hDEADBE000000000000000000);
        check("t5_tuser", BW'(bus.m_axis_tuser), 1);
        drain();
        g0 = got;
        for (int i = 0; i < 100; i++) step();
        check("t5_empty_noflush", BW'(got - g0 + int'(bus.m_axis_tvalid)), 0);

        // Test 6: byte on the expiry cycle wins
        send_byte(8'h01); send_byte(8'h02); send_byte(8'h03);
        for (int i = 0; i < TMO - 1; i++) step();
        send_byte(8'h04);
        check("t6_fill", BW'(bus.fill_level), 4);
        check("t6_no_flush", BW'(bus.m_axis_tvalid), 0);
        for (int i = 0; i < NB - 4; i++) send_byte(8'h05 + 8'(i));
        check("t6_tuser", BW'(bus.m_axis_tuser), 0);
        check("t6_data", bus.m_axis_tdata, 96'h0102030405060708090A0B0C);
        drain();
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
